// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic {
    ST_IDLE,
    ST_RD_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Counts consecutive cycles fetch lost to the data port; at_max forces fetch to win.
module arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX_C = 4'(MAX_WAIT);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single-port memory with fixed read latency.
// Zero-cycle combinational grant in IDLE; data wins unless fetch has starved MAX_WAIT times.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  arb_state_t state, state_nxt;
  arb_owner_t owner, owner_nxt;
  logic [2:0] lat_cnt, lat_nxt;
  logic       at_max;

  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (if_req & d_gnt),
    .clr    (if_gnt | ~if_req),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= OWN_NONE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      lat_cnt <= lat_nxt;
    end
  end

  // Outputs are gated by rst_n so nothing escapes while reset is held.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    lat_nxt   = lat_cnt;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (if_req && (at_max || !d_req)) begin
            if_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            state_nxt = ST_RD_WAIT;
            owner_nxt = OWN_IF;
            lat_nxt   = RD_LAT_C;
          end else if (d_req) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (!d_we) begin
              state_nxt = ST_RD_WAIT;
              owner_nxt = OWN_D;
              lat_nxt   = RD_LAT_C;
            end
          end
        end
        ST_RD_WAIT: begin
          lat_nxt = lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            if (owner == OWN_IF) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
            if (owner == OWN_D) begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end
            state_nxt = ST_IDLE;
            owner_nxt = OWN_NONE;
            lat_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          owner_nxt = OWN_NONE;
          lat_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: dut_a (RD_LAT=1) for arbitration/timing, dut_b (RD_LAT=3) for reset-in-RD_WAIT.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

  int total = 0;
  int bad   = 0;
  int pulses;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst_n(rst_a),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst_n(rst_b),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // inputs change just after posedge; outputs sampled on the negedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h40; d_addr = 32'h100; d_wdata = 32'h0; mem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_if_gnt", {31'd0, a_if_gnt}, 32'd0);
    chk("rst_d_gnt",  {31'd0, a_d_gnt},  32'd0);
    chk("rst_mem_en", {31'd0, a_mem_en}, 32'd0);
    chk("rst_addr",   a_mem_addr,        32'd0);

    // fetch read, first cycle after reset release
    next_cycle();
    rst_a = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("f_if_gnt",  {31'd0, a_if_gnt},  32'd1);
    chk("f_mem_en",  {31'd0, a_mem_en},  32'd1);
    chk("f_addr",    a_mem_addr,         32'h40);
    chk("f_we",      {31'd0, a_mem_we},  32'd0);
    next_cycle();
    if_req = 1'b0; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("f_rvalid",  {31'd0, a_if_rvalid}, 32'd1);
    chk("f_rdata",   a_if_rdata,           32'h1234_5678);
    chk("f_no_drv",  {31'd0, a_d_rvalid},  32'd0);
    chk("f_d_rdata", a_d_rdata,            32'd0);
    chk("f_rw_en",   {31'd0, a_mem_en},    32'd0);

    // simultaneous requests: data read first, fetch at RD_LAT+1
    next_cycle();
    chk("idle_rdata", a_if_rdata, 32'd0);
    if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    chk("s_d_gnt",  {31'd0, a_d_gnt},  32'd1);
    chk("s_if_gnt", {31'd0, a_if_gnt}, 32'd0);
    chk("s_addr",   a_mem_addr,        32'h100);
    next_cycle();
    d_req = 1'b0; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("s1_if_gnt", {31'd0, a_if_gnt},   32'd0);
    chk("s1_drv",    {31'd0, a_d_rvalid}, 32'd1);
    chk("s1_drdata", a_d_rdata,           32'hCAFE_0001);
    chk("s1_ifrd",   a_if_rdata,          32'd0);
    next_cycle();
    @(negedge clk);
    chk("s2_if_gnt", {31'd0, a_if_gnt}, 32'd1);
    chk("s2_addr",   a_mem_addr,        32'h44);
    next_cycle();
    if_req = 1'b0; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("s3_ifrv",   {31'd0, a_if_rvalid}, 32'd1);
    chk("s3_ifrd",   a_if_rdata,           32'h0BAD_F00D);

    // store: completes in grant cycle, no rvalid
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("w_d_gnt", {31'd0, a_d_gnt},  32'd1);
    chk("w_we",    {31'd0, a_mem_we}, 32'd1);
    chk("w_addr",  a_mem_addr,        32'h8);
    chk("w_data",  a_mem_wdata,       32'hDEAD_BEEF);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    chk("w_no_drv",  {31'd0, a_d_rvalid},  32'd0);
    chk("w_no_ifrv", {31'd0, a_if_rvalid}, 32'd0);

    // starvation: four stores win, fifth cycle goes to fetch
    next_cycle();
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("st%0d_d_gnt", i),  {31'd0, a_d_gnt},  (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("st%0d_if_gnt", i), {31'd0, a_if_gnt}, (i < 4) ? 32'd0 : 32'd1);
      next_cycle();
    end
    if_req = 1'b0; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("st_ifrv",  {31'd0, a_if_rvalid}, 32'd1);
    chk("st_rw_dg", {31'd0, a_d_gnt},     32'd0);
    next_cycle();
    d_req = 1'b0; d_we = 1'b0;

    // RD_LAT=3: normal read timing
    rst_b = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("b_gnt", {31'd0, b_if_gnt}, 32'd1);
    next_cycle();
    if_req = 1'b0; mem_rdata = 32'h7777_0003;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("b_rv_c%0d", i), {31'd0, b_if_rvalid}, (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("b_rd_c%0d", i), b_if_rdata, (i == 3) ? 32'h7777_0003 : 32'd0);
      next_cycle();
    end

    // RD_LAT=3: reset in first RD_WAIT cycle abandons the read
    if_req = 1'b1;
    @(negedge clk);
    chk("br_gnt", {31'd0, b_if_gnt}, 32'd1);
    next_cycle();
    if_req = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("br_rst_rv", {31'd0, b_if_rvalid}, 32'd0);
    chk("br_rst_en", {31'd0, b_mem_en},    32'd0);
    chk("br_rst_rd", b_if_rdata,           32'd0);
    next_cycle();
    rst_b = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
    pulses = 0;
    @(negedge clk);
    chk("br_rel_gnt", {31'd0, b_d_gnt}, 32'd1);
    if (b_if_rvalid || b_d_rvalid) pulses++;
    next_cycle();
    d_req = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b_if_rvalid || b_d_rvalid) pulses++;
      next_cycle();
    end
    chk("br_no_rvalid", pulses, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width of all address ports.
REQ-002 Parameter DW, default 32: data width of all data ports.
REQ-003 Parameter RD_LAT, default 1 (legal range 1..7): fixed memory read latency in cycles.
REQ-004 Parameter MAX_WAIT, default 4 (legal range 1..15): number of consecutive lost arbitrations before fetch is forced to win.
REQ-005 clk  in  1  clock; all state changes on posedge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 if_req  in  1  instruction-fetch read request.
REQ-008 if_addr  in  AW  fetch address.
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_rvalid  out  1  fetch read data valid (1-cycle pulse).
REQ-011 if_rdata  out  DW  fetch read data.
REQ-012 d_req  in  1  data-port request (lw/sw).
REQ-013 d_we  in  1  data-port write enable (1 = sw).
REQ-014 d_addr  in  AW  data-port address.
REQ-015 d_wdata  in  DW  data-port write data.
REQ-016 d_gnt  out  1  data request accepted this cycle.
REQ-017 d_rvalid  out  1  data read data valid (1-cycle pulse).
REQ-018 d_rdata  out  DW  data read data.
REQ-019 mem_en  out  1  single-port memory access strobe.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_addr  out  AW  memory address.
REQ-022 mem_wdata  out  DW  memory write data.
REQ-023 mem_rdata  in  DW  memory read data, valid RD_LAT cycles after a read strobe.

Function
REQ-024 The block SHALL implement the FSM {IDLE, RD_WAIT}; grants SHALL be issued only in IDLE.
REQ-025 In IDLE with any request, the block SHALL combinationally assert exactly one gnt and drive mem_en=1, mem_addr, mem_we and mem_wdata from the winner in the same cycle (zero-cycle grant latency); mem_we and mem_wdata SHALL be 0 for a fetch.
REQ-026 Priority: the data port SHALL win by default; fetch SHALL win when starve_cnt == MAX_WAIT.
REQ-027 starve_cnt SHALL increment (saturating at MAX_WAIT) on each cycle where if_req=1 and d_gnt=1; it SHALL clear on if_gnt and whenever if_req=0.
REQ-028 A granted write (d_we=1) SHALL complete in the grant cycle; the FSM SHALL stay in IDLE, so back-to-back grants are allowed.
REQ-029 A granted read SHALL latch the owner (IF or D), load lat_cnt=RD_LAT, and move to RD_WAIT.
REQ-030 In RD_WAIT, lat_cnt SHALL decrement each cycle; when it reaches 1, the owner's rvalid SHALL pulse high for one cycle, its rdata SHALL equal mem_rdata, and the FSM SHALL return to IDLE the next cycle.
REQ-031 Read throughput: the next grant SHALL occur no earlier than RD_LAT+1 cycles after a read grant.
REQ-032 In RD_WAIT, gnt, mem_en and mem_we SHALL be 0; requests SHALL be held, not dropped.
REQ-033 Requesters hold req, addr, we and wdata stable until gnt; the block SHALL NOT register request fields.
REQ-034 rdata of the non-owner and of both ports outside rvalid SHALL be 0.
REQ-035 When if_req and d_req rise together with starve_cnt < MAX_WAIT, d SHALL win.

Reset
REQ-036 With rst_n low, the block SHALL force state IDLE, owner none, lat_cnt=0, starve_cnt=0, and all outputs to 0 regardless of requests.
REQ-037 Reset during RD_WAIT SHALL abandon the read: no rvalid pulse after deassertion.
REQ-038 After rst_n rises, the first grant SHALL be possible in the first clock cycle.

Structure
REQ-039 A shared package SHALL hold the state enum, the owner encoding {NONE, IF, D}, and the AW/DW default constants.
REQ-040 The starvation counter SHALL be a sub-module arb_starve_cnt (inputs: inc, clr; output: at_max).

Verification
REQ-041 Fetch read, RD_LAT=1: if_req with if_addr=0x40 -> if_gnt and mem_en in cycle 0, then if_rvalid with if_rdata=mem_rdata in cycle 1, no d_rvalid.
REQ-042 Simultaneous if_req/d_req (d_we=0, d_addr=0x100) -> d_gnt first; if_gnt at cycle RD_LAT+1.
REQ-043 d_req held high with continuous sw (d_we=1) and if_req high, MAX_WAIT=4 -> 4 d grants, then if_gnt on the 5th cycle.
REQ-044 sw d_addr=0x8, d_wdata=0xDEADBEEF -> mem_we=1 with matching addr/data in the grant cycle; no rvalid pulse.
REQ-045 RD_LAT=3: assert rst_n low in cycle 1 of RD_WAIT -> outputs 0, no rvalid ever; grant allowed in the first cycle after release.
